// File: rtl/ad7606c_spi_master.sv
// SPI master for the AD7606C secondary ADC: runs data-read and register-write frames,
// drives SCLK/CS_N/MOSI and deserialises the parallel DOUT lines into eight channel words.
module ad7606c_spi_master #(
  parameter int CLK_DIV  = 4,
  parameter int DOUT_NUM = 2
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_adc_spi_start,
  output logic                o_adc_spi_done,
  input  logic                i_init_spi_start,
  output logic                o_init_spi_done,
  input  logic [15:0]         i_init_data,
  input  logic                i_cpol,
  input  logic                i_cpha,
  output logic                o_sclk,
  output logic                o_cs_n,
  output logic                o_mosi,
  input  logic [DOUT_NUM-1:0] i_dout,
  output logic [15:0]         o_adc_data_0,
  output logic [15:0]         o_adc_data_1,
  output logic [15:0]         o_adc_data_2,
  output logic [15:0]         o_adc_data_3,
  output logic [15:0]         o_adc_data_4,
  output logic [15:0]         o_adc_data_5,
  output logic [15:0]         o_adc_data_6,
  output logic [15:0]         o_adc_data_7,
  output logic [15:0]         o_init_rdata,
  output logic                o_busy
);

  localparam int         RD_BITS      = 128 / DOUT_NUM;
  localparam int         R0_LSB       = 128 - RD_BITS;
  localparam logic [7:0] DIV_LAST     = 8'(CLK_DIV - 1);
  localparam logic [8:0] RD_EDGE_LAST = 9'(2 * RD_BITS - 1);
  localparam logic [8:0] WR_EDGE_LAST = 9'd31;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CS_SETUP,
    S_SHIFT,
    S_CS_HOLD,
    S_DONE
  } state_t;

  state_t         state_q, state_d;
  logic [7:0]     div_q, div_d;
  logic [8:0]     edge_q, edge_d;
  logic           init_frame_q, init_frame_d;
  logic           cpol_q, cpol_d;
  logic           cpha_q, cpha_d;
  logic           sclk_q, sclk_d;
  logic           cs_n_q, cs_n_d;
  logic           mosi_q, mosi_d;
  logic           busy_q, busy_d;
  logic           adc_done_q, adc_done_d;
  logic           init_done_q, init_done_d;
  logic [127:0]   ch_q, ch_d;
  logic [15:0]    init_rdata_q, init_rdata_d;
  logic [15:0]    tx_q, tx_d;
  logic [127:0]   rx_q, rx_d;
  logic [127:0]   rx_shift;
  logic [8:0]     edge_last;

  // Line 0 occupies the top of rx, so after a full read frame the vector reads ch0..ch7 from the MSB down.
  for (genvar k = 0; k < DOUT_NUM; k++) begin : g_line
    localparam int HI = 127 - k * RD_BITS;
    assign rx_shift[HI -: RD_BITS] = {rx_q[HI-1 -: RD_BITS-1], i_dout[k]};
  end

  assign edge_last = init_frame_q ? WR_EDGE_LAST : RD_EDGE_LAST;

  always_comb begin
    state_d      = state_q;
    div_d        = div_q;
    edge_d       = edge_q;
    init_frame_d = init_frame_q;
    cpol_d       = cpol_q;
    cpha_d       = cpha_q;
    sclk_d       = sclk_q;
    cs_n_d       = cs_n_q;
    mosi_d       = mosi_q;
    busy_d       = busy_q;
    adc_done_d   = 1'b0;
    init_done_d  = 1'b0;
    ch_d         = ch_q;
    init_rdata_d = init_rdata_q;
    tx_d         = tx_q;
    rx_d         = rx_q;

    case (state_q)
      S_IDLE: begin
        sclk_d = i_cpol;
        div_d  = 8'd0;
        edge_d = 9'd0;
        // Init start wins a tie; the adc start is simply dropped.
        if (i_init_spi_start || i_adc_spi_start) begin
          state_d      = S_CS_SETUP;
          init_frame_d = i_init_spi_start;
          cpol_d       = i_cpol;
          cpha_d       = i_cpha;
          busy_d       = 1'b1;
          cs_n_d       = 1'b0;
          mosi_d       = 1'b0;
          tx_d         = i_init_data;
          if (i_init_spi_start && !i_cpha) begin
            mosi_d = i_init_data[15];
            tx_d   = {i_init_data[14:0], 1'b0};
          end
        end
      end

      S_CS_SETUP: begin
        div_d = div_q + 8'd1;
        if (div_q == DIV_LAST) begin
          div_d   = 8'd0;
          state_d = S_SHIFT;
        end
      end

      S_SHIFT: begin
        div_d = div_q + 8'd1;
        if (div_q == DIV_LAST) begin
          div_d  = 8'd0;
          sclk_d = ~sclk_q;
          edge_d = edge_q + 9'd1;
          // Even edge counts are leading edges; capture uses i_dout before this toggle lands.
          if (edge_q[0] == cpha_q) begin
            rx_d = rx_shift;
          end else if (init_frame_q) begin
            mosi_d = tx_q[15];
            tx_d   = {tx_q[14:0], 1'b0};
          end
          if (edge_q == edge_last) begin
            edge_d  = 9'd0;
            state_d = S_CS_HOLD;
          end
        end
      end

      S_CS_HOLD: begin
        div_d = div_q + 8'd1;
        if (div_q == DIV_LAST) begin
          div_d   = 8'd0;
          state_d = S_DONE;
          if (init_frame_q) begin
            init_done_d  = 1'b1;
            init_rdata_d = rx_q[R0_LSB +: 16];
          end else begin
            adc_done_d = 1'b1;
            ch_d       = rx_q;
          end
        end
      end

      S_DONE: begin
        // CS_N is released leaving DONE so back-to-back frames see exactly one idle CS_N cycle.
        state_d = S_IDLE;
        busy_d  = 1'b0;
        cs_n_d  = 1'b1;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= S_IDLE;
      div_q        <= 8'd0;
      edge_q       <= 9'd0;
      init_frame_q <= 1'b0;
      cpol_q       <= 1'b0;
      cpha_q       <= 1'b0;
      sclk_q       <= 1'b0;
      cs_n_q       <= 1'b1;
      mosi_q       <= 1'b0;
      busy_q       <= 1'b0;
      adc_done_q   <= 1'b0;
      init_done_q  <= 1'b0;
      ch_q         <= '0;
      init_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      edge_q       <= edge_d;
      init_frame_q <= init_frame_d;
      cpol_q       <= cpol_d;
      cpha_q       <= cpha_d;
      sclk_q       <= sclk_d;
      cs_n_q       <= cs_n_d;
      mosi_q       <= mosi_d;
      busy_q       <= busy_d;
      adc_done_q   <= adc_done_d;
      init_done_q  <= init_done_d;
      ch_q         <= ch_d;
      init_rdata_q <= init_rdata_d;
    end
  end

  // Shift registers are fully rewritten by every frame before use, so they carry no reset.
  always_ff @(posedge i_clk) begin
    tx_q <= tx_d;
    rx_q <= rx_d;
  end

  assign o_sclk          = sclk_q;
  assign o_cs_n          = cs_n_q;
  assign o_mosi          = mosi_q;
  assign o_busy          = busy_q;
  assign o_adc_spi_done  = adc_done_q;
  assign o_init_spi_done = init_done_q;
  assign o_init_rdata    = init_rdata_q;
  assign o_adc_data_0    = ch_q[127:112];
  assign o_adc_data_1    = ch_q[111:96];
  assign o_adc_data_2    = ch_q[95:80];
  assign o_adc_data_3    = ch_q[79:64];
  assign o_adc_data_4    = ch_q[63:48];
  assign o_adc_data_5    = ch_q[47:32];
  assign o_adc_data_6    = ch_q[31:16];
  assign o_adc_data_7    = ch_q[15:0];

endmodule

// File: doc/ad7606c_spi_master.md
Name: ad7606c_spi_master

Overview:
SPI master serving the AD7606C secondary ADC. It answers the sequencer's data-read and init-write start/done handshakes. It generates SCLK/CS_N/MOSI and deserialises the parallel DOUT lines into eight 16-bit channel words. It sits between the AD7606C sequencer and the ADC pins.

Parameters:
CLK_DIV, 4, i_clk cycles per SCLK half-period; legal values are 2..255.
DOUT_NUM, 2, number of ADC DOUT lines; legal values are 1, 2, 4, 8.

Ports:
i_clk  in  1  system clock
i_rst  in  1  reset, asynchronous, active-high
i_adc_spi_start  in  1  one-cycle pulse; starts a data-read frame
o_adc_spi_done  out  1  one-cycle pulse; read frame complete, channel data valid
i_init_spi_start  in  1  one-cycle pulse; starts a register-write frame
o_init_spi_done  out  1  one-cycle pulse; write frame complete
i_init_data  in  16  register-write word, MSB first
i_cpol  in  1  SCLK idle level
i_cpha  in  1  0: sample on leading edge; 1: sample on trailing edge
o_sclk  out  1  SPI clock
o_cs_n  out  1  chip select, active low
o_mosi  out  1  serial data to ADC
i_dout  in  DOUT_NUM  serial data from ADC
o_adc_data_0 .. o_adc_data_7  out  16 each  channel words
o_init_rdata  out  16  word captured on i_dout[0] during the last write frame
o_busy  out  1  high from the accepted start until the done pulse, inclusive

Behaviour:
- Reset values: o_sclk=0, o_cs_n=1, o_mosi=0, both done outputs=0, o_busy=0, all channel words=0, o_init_rdata=0, state=IDLE. Reset mid-frame aborts at once and no done pulse is issued.
- States: IDLE -> CS_SETUP -> SHIFT -> CS_HOLD -> DONE -> IDLE.
- IDLE:
  - o_sclk follows i_cpol.
  - A start pulse seen in cycle 0 is accepted. At the cycle-0 edge, latch i_cpol, i_cpha and i_init_data, and set the frame type.
  - From cycle 1: o_cs_n=0, o_busy=1.
- Start arbitration:
  - If both starts arrive in the same cycle, the init frame runs and the adc start is dropped.
  - Any start while o_busy=1 is ignored; no queueing.
- Frame length N:
  - Read frame: N = 128/DOUT_NUM bits.
  - Init frame: N = 16 bits.
- CS_SETUP lasts CLK_DIV cycles.
- SHIFT:
  - An SCLK edge occurs every CLK_DIV cycles, giving 2N edges and 2*N*CLK_DIV cycles in total.
  - o_sclk ends at its latched idle level.
- MOSI, init frame:
  - CPHA=0: bit 15 is driven from CS_SETUP entry; the next bit is driven on each trailing edge.
  - CPHA=1: a new bit is driven on each leading edge, starting with bit 15.
- MOSI, read frame: held at 0.
- Sampling:
  - i_dout is sampled on the latched sampling edge, in the same i_clk cycle that toggles o_sclk. Capture uses the pre-toggle value.
  - Shift registers fill MSB first. No synchronisers are used.
- Read frame channel mapping: DOUT line k carries channels k*(8/DOUT_NUM) upward in ascending order, each channel MSB first.
- CS_HOLD lasts CLK_DIV cycles, then o_cs_n=1.
- DONE (one cycle):
  - Pulse the matching done output.
  - Read frame: all eight channel words update together on this edge and are valid while done=1.
  - Init frame: o_init_rdata updates on this edge.
  - o_busy drops the cycle after DONE.
- Latency from start at cycle 0 to done: 1 + 2*CLK_DIV + 2*N*CLK_DIV cycles.
  - Defaults, read frame: 521 cycles.
  - Defaults, init frame: 137 cycles.
- Outputs hold their last values between frames.
- A new start is accepted in the cycle after DONE.

Test Plan:
- Read frame, CPOL=0/CPHA=0, defaults. The ADC model shifts 0x1111,0x2222,...,0x8888 (ch0–3 on dout[0], ch4–7 on dout[1]). Required: done at cycle 521; o_adc_data_n = 0x(n+1)(n+1)(n+1)(n+1); exactly 64 rising edges while CS_N is low.
- Init frame, i_init_data=0x0285, CPOL=1/CPHA=1. Required:
  - MOSI captured on rising (trailing) edges reads 0x0285.
  - Model returns 0xA5C3 on dout[0]; o_init_rdata=0xA5C3.
  - o_init_spi_done at cycle 137; o_sclk idles high.
- Both starts pulsed in the same cycle, followed by an adc start at cycle 50. Required: only an init frame runs; only o_init_spi_done pulses; o_adc_spi_done never asserts.
- i_rst asserted at cycle 200 of a read frame. Required: o_cs_n=1, o_sclk=0, o_busy=0 immediately; no done pulse; channel words stay 0; the next read completes normally.
- DOUT_NUM=1, CLK_DIV=2. Required:
  - 128-bit frame; done at cycle 1+4+512=517.
  - Channels taken from dout[0] in order ch0..ch7.
- Back-to-back reads, with the second start issued the cycle after DONE. Required: second frame accepted; CS_N high for exactly 1 cycle between frames; data updates on each done.
